// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: op codes, arbiter FSM states
// and bit positions inside the {OF,ZF,CF,SF} flag bus.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  localparam int FLAG_SF = 0;
  localparam int FLAG_CF = 1;
  localparam int FLAG_ZF = 2;
  localparam int FLAG_OF = 3;

endpackage

// File: rtl/alu_core.sv
// Purely combinational WIDTH-bit ALU. Arithmetic ops share one adder; result
// is WIDTH+1 bits so the carry of add/sub is visible in the top bit.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   data,
  output logic             of,
  output logic             zf,
  output logic             cf,
  output logic             sf
);

  logic             use_sub;
  logic             arith;
  logic [WIDTH-1:0] b_add;
  logic [WIDTH:0]   sum;
  logic             sum_of;
  logic [WIDTH-1:0] logic_res;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    use_sub   = (op == OP_SUB) || (op == OP_SLT) || (op == OP_EQ);
    arith     = use_sub || (op == OP_ADD);
    b_add     = use_sub ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_add} + {{WIDTH{1'b0}}, use_sub};
    // Signed overflow: both addends share a sign that the result does not.
    sum_of    = (a[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    logic_res = '0;
    data      = '0;
    of        = 1'b0;
    zf        = 1'b0;
    cf        = 1'b0;
    sf        = 1'b0;

    case (op)
      OP_NOT:  logic_res = ~a;
      OP_AND:  logic_res = a & b;
      OP_OR:   logic_res = a | b;
      OP_XOR:  logic_res = a ^ b;
      default: logic_res = '0;
    endcase

    if (arith) begin
      case (op)
        OP_SLT:  data = {{WIDTH{1'b0}}, sum[WIDTH-1] ^ sum_of};
        OP_EQ:   data = {{WIDTH{1'b0}}, sum[WIDTH-1:0] == '0};
        default: data = sum;
      endcase
      of = sum_of;
      zf = (sum[WIDTH-1:0] == '0);
      cf = sum[WIDTH];
      sf = sum[WIDTH-1];
    end else begin
      data = {1'b0, logic_res};
      zf   = (logic_res == '0);
      sf   = logic_res[WIDTH-1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu_core between N_REQ requesters with a
// single operation in flight: IDLE (grant) -> EXEC (compute) -> RESP (return).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int N_REQ = 2,
  parameter  int WIDTH = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [3*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH:0]         rsp_data,
  output logic [3:0]             rsp_flags,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy,
  output logic [7:0]             op_count
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_grant_q;
  logic [IDW-1:0]   grant_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             handshake;

  logic [WIDTH:0]   alu_data;
  logic             alu_of, alu_zf, alu_cf, alu_sf;
  logic [3:0]       alu_flags;

  // Search starts one past the last completed owner so every requester gets a turn.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(last_grant_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && req_valid[idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  assign handshake = (state_q == S_RESP) && rsp_ready[rsp_id];

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          state_d              = S_EXEC;
        end
      end
      S_EXEC: begin
        busy    = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        busy              = 1'b1;
        rsp_valid[rsp_id] = 1'b1;
        if (handshake) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .data (alu_data),
    .of   (alu_of),
    .zf   (alu_zf),
    .cf   (alu_cf),
    .sf   (alu_sf)
  );

  always_comb begin
    alu_flags          = '0;
    alu_flags[FLAG_OF] = alu_of;
    alu_flags[FLAG_ZF] = alu_zf;
    alu_flags[FLAG_CF] = alu_cf;
    alu_flags[FLAG_SF] = alu_sf;
  end

  // Result registers are only written in EXEC, so they hold across IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= IDW'(N_REQ - 1);
      grant_q      <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data     <= '0;
      rsp_flags    <= '0;
      rsp_id       <= '0;
      op_count     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            grant_q <= grant_idx;
            op_q    <= sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
          end
        end
        S_EXEC: begin
          rsp_data  <= alu_data;
          rsp_flags <= alu_flags;
          rsp_id    <= grant_q;
        end
        S_RESP: begin
          if (handshake) begin
            last_grant_q <= grant_q;
            op_count     <= op_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (N_REQ=2, WIDTH=4): a transaction-level
// model checks every cycle; directed ops carry hand-computed expectations.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 2;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_op = '0;
  logic [W*N-1:0] req_a = '0;
  logic [W*N-1:0] req_b = '0;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '0;
  logic [W:0]     rsp_data;
  logic [3:0]     rsp_flags;
  logic           rsp_id;
  logic           busy;
  logic [7:0]     op_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from signed/unsigned integer arithmetic; returns {data, OF,ZF,CF,SF}.
  function automatic logic [8:0] alu_model(input logic [2:0] op, input int a, input int b);
    int sa, sb, r, d;
    bit of, zf, cf, sf;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    of = 0; zf = 0; cf = 0; sf = 0; d = 0;
    case (op)
      OP_ADD: begin
        d  = a + b;
        r  = sa + sb;
        of = (r > 7) || (r < -8);
        cf = (d > 15);
        zf = (d % 16) == 0;
        sf = (d % 16) >= 8;
      end
      OP_SUB, OP_SLT, OP_EQ: begin
        r  = sa - sb;
        of = (r > 7) || (r < -8);
        cf = (a >= b);
        zf = (a == b);
        sf = ((a - b + 16) % 16) >= 8;
        if (op == OP_SUB)      d = a - b + 16;
        else if (op == OP_SLT) d = (sa < sb) ? 1 : 0;
        else                   d = (a == b) ? 1 : 0;
      end
      default: begin
        case (op)
          OP_NOT:  d = 15 - a;
          OP_AND:  d = a & b;
          OP_OR:   d = a | b;
          default: d = a ^ b;
        endcase
        zf = (d == 0);
        sf = (d >= 8);
      end
    endcase
    return {d[4:0], of, zf, cf, sf};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (last + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // Transaction-level model: idle, or holding one op accepted m_since cycles ago.
  bit         m_busy = 0;
  bit         m_has = 0;
  int         m_owner = 0;
  int         m_since = 0;
  int         m_last = N - 1;
  int         m_count = 0;
  int         m_g;
  logic [8:0] m_exp = '0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 0;
      m_has   = 0;
      m_owner = 0;
      m_since = 0;
      m_last  = N - 1;
      m_count = 0;
    end else begin
      check("op_count", 32'(op_count), 32'(m_count % 256));
      if (!m_busy) begin
        m_g = rr_pick(req_valid, m_last);
        check("req_ready", 32'(req_ready), (m_g < 0) ? 32'd0 : 32'(1 << m_g));
        check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        if (m_has) check("rsp_hold", 32'({rsp_data, rsp_flags}), 32'(m_exp));
        if (m_g >= 0) begin
          m_busy  = 1;
          m_owner = m_g;
          m_since = 0;
          m_exp   = alu_model(req_op[3*m_g +: 3], int'(req_a[W*m_g +: W]), int'(req_b[W*m_g +: W]));
        end
      end else begin
        check("req_ready_busy", 32'(req_ready), 32'd0);
        check("busy", 32'(busy), 32'd1);
        if (m_since == 0) begin
          check("rsp_valid_exec", 32'(rsp_valid), 32'd0);
        end else begin
          check("rsp_valid", 32'(rsp_valid), 32'(1 << m_owner));
          check("rsp_id", 32'(rsp_id), 32'(m_owner));
          check("rsp_result", 32'({rsp_data, rsp_flags}), 32'(m_exp));
          if (rsp_ready[m_owner]) begin
            m_busy  = 0;
            m_has   = 1;
            m_last  = m_owner;
            m_count = m_count + 1;
          end
        end
        m_since++;
      end
    end
  end

  task automatic drive_req(input int r, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    req_valid[r]      = 1'b1;
    req_op[3*r +: 3]  = op;
    req_a[W*r +: W]   = a;
    req_b[W*r +: W]   = b;
  endtask

  task automatic wait_ready(input int r, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[r] && n < 20);
    if (!req_ready[r]) check({nm, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int r, input string nm, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[r] && lat < 10);
    if (!rsp_valid[r]) check({nm, "_rsp_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_op(input int r, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [4:0] ed, input logic [3:0] ef, input string nm);
    int lat;
    @(posedge clk); #1;
    drive_req(r, op, a, b);
    wait_ready(r, nm);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    wait_rsp(r, nm, lat);
    check({nm, "_latency"}, 32'(lat), 32'd2);
    check({nm, "_data"}, 32'(rsp_data), 32'(ed));
    check({nm, "_flags"}, 32'(rsp_flags), 32'(ef));
    check({nm, "_id"}, 32'(rsp_id), 32'(r));
    @(posedge clk); #1;
    rsp_ready[r] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[r] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ids[4];
    int seen;
    int n;

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_op_count", 32'(op_count), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_rsp_flags", 32'(rsp_flags), 32'd0);
    rst_n = 1'b1;

    // Flags are {OF,ZF,CF,SF}.
    do_op(0, OP_ADD, 4'h7, 4'h9, 5'h10, 4'b0110, "add_7_9");
    do_op(1, OP_SUB, 4'h3, 4'h5, 5'h0E, 4'b0001, "sub_3_5");
    do_op(1, OP_ADD, 4'h7, 4'h1, 5'h08, 4'b1001, "add_7_1");
    do_op(0, OP_SLT, 4'hE, 4'h1, 5'h01, 4'b0011, "slt_e_1");
    do_op(0, OP_SLT, 4'h3, 4'hF, 5'h00, 4'b0000, "slt_3_f");
    do_op(0, OP_EQ,  4'h6, 4'h6, 5'h01, 4'b0110, "eq_6_6");

    // Stall in RESP with a competing requester pending.
    @(posedge clk); #1;
    drive_req(0, OP_OR, 4'h5, 4'hA);
    wait_ready(0, "stall");
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    drive_req(1, OP_XOR, 4'h3, 4'h3);
    wait_rsp(0, "stall", lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'b01);
      check("stall_result", 32'({rsp_data, rsp_flags}), 32'({5'h0F, 4'b0001}));
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    check("stall_release_busy", 32'(busy), 32'd0);
    check("stall_release_rsp_valid", 32'(rsp_valid), 32'd0);
    check("op_count_after_7", 32'(op_count), 32'd7);

    // Reset while requester 1 is waiting in RESP.
    @(posedge clk); #1;
    drive_req(1, OP_ADD, 4'h1, 4'h1);
    wait_ready(1, "mid_reset");
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(1, "mid_reset", lat);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_reset_op_count", 32'(op_count), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    #1;
    rst_n = 1'b1;

    // Both requesters held valid from reset: grants alternate starting at 0.
    @(posedge clk); #1;
    drive_req(0, OP_ADD, 4'h1, 4'h2);
    drive_req(1, OP_XOR, 4'h5, 4'h3);
    rsp_ready = 2'b11;
    seen = 0;
    n = 0;
    while (seen < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (rsp_valid != '0) begin
        ids[seen] = int'(rsp_id);
        seen++;
      end
    end
    check("rr_responses", 32'(seen), 32'd4);
    check("rr_grant0", 32'(ids[0]), 32'd0);
    check("rr_grant1", 32'(ids[1]), 32'd1);
    check("rr_grant2", 32'(ids[2]), 32'd0);
    check("rr_grant3", 32'(ids[3]), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = '0;
    @(negedge clk);
    check("rr_op_count", 32'(op_count), 32'd4);
    check("rr_last_data", 32'({rsp_data, rsp_flags}), 32'({5'h06, 4'b0000}));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
